// File: rtl/delay_scan_pkg.sv
// Shared types and constants for the ADC delay-scan sequencer.
package delay_scan_pkg;

    localparam int DLY_W   = 6;
    localparam int MOD_W   = 7;
    localparam int CNT_W   = 7;
    localparam int DLY_MAX = 63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_LOAD,
        ST_SETTLE,
        ST_MEAS,
        ST_NEXT
    } state_t;

    // One bit wider than a delay so the top-of-range overflow stays visible.
    function automatic logic [DLY_W:0] next_delay(input logic [DLY_W-1:0] dly,
                                                  input logic [DLY_W-1:0] step);
        logic [DLY_W-1:0] eff;
        eff = (step == '0) ? DLY_W'(1) : step;
        return {1'b0, dly} + {1'b0, eff};
    endfunction

endpackage

// File: rtl/delay_scan_settle_timer.sv
// Loadable down-counter that stops at zero and flags it.
module delay_scan_settle_timer #(
    parameter int SETTLE_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [SETTLE_W-1:0] i_value,
    input  logic                i_dec,
    output logic                o_zero
);

    logic [SETTLE_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - SETTLE_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/delay_scan_ctrl.sv
// Scan sequencer: steps scan_delay through delay_calc, loads the IODELAY,
// settles, requests a measurement, and slots in delay_modifier updates.
module delay_scan_ctrl
    import delay_scan_pkg::*;
#(
    parameter int SETTLE_W = 8
) (
    input  logic                i_clk40,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [5:0]          i_scan_first,
    input  logic [5:0]          i_scan_last,
    input  logic [5:0]          i_scan_step,
    input  logic [SETTLE_W-1:0] i_settle_cycles,
    input  logic                i_stop_on_sat,
    input  logic                i_saturated,
    input  logic                i_mod_req,
    input  logic [6:0]          i_mod_value,
    output logic                o_mod_ack,
    output logic                o_meas_req,
    input  logic                i_meas_done,
    output logic [5:0]          o_scan_delay,
    output logic [6:0]          o_delay_modifier,
    output logic                o_strb,
    output logic                o_dly_load,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_sat_flag,
    output logic [6:0]          o_step_count
);

    state_t             r_state;
    logic               r_single;
    logic               r_mod_ack;
    logic               r_meas_req;
    logic [DLY_W-1:0]   r_scan_delay;
    logic [MOD_W-1:0]   r_delay_modifier;
    logic               r_strb;
    logic               r_dly_load;
    logic               r_busy;
    logic               r_done;
    logic               r_sat_flag;
    logic [CNT_W-1:0]   r_step_count;

    logic [DLY_W:0]     w_nxt;
    logic               w_last;
    logic               w_tmr_zero;
    logic               w_tmr_load;
    logic               w_tmr_dec;

    assign w_nxt  = next_delay(r_scan_delay, i_scan_step);
    assign w_last = (w_nxt > {1'b0, i_scan_last}) || (w_nxt > (DLY_W+1)'(DLY_MAX));

    // LOAD only falls through to SETTLE when settle_cycles is non-zero, so
    // loading N-1 gives exactly N SETTLE cycles.
    assign w_tmr_load = (r_state == ST_LOAD);
    assign w_tmr_dec  = (r_state == ST_SETTLE);

    delay_scan_settle_timer #(
        .SETTLE_W (SETTLE_W)
    ) u_settle (
        .i_clk   (i_clk40),
        .i_rst_n (i_rst_n),
        .i_load  (w_tmr_load),
        .i_value (i_settle_cycles - SETTLE_W'(1)),
        .i_dec   (w_tmr_dec),
        .o_zero  (w_tmr_zero)
    );

    always_ff @(posedge i_clk40 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_single         <= 1'b0;
            r_mod_ack        <= 1'b0;
            r_meas_req       <= 1'b0;
            r_scan_delay     <= '0;
            r_delay_modifier <= '0;
            r_strb           <= 1'b0;
            r_dly_load       <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_sat_flag       <= 1'b0;
            r_step_count     <= '0;
        end else begin
            r_strb     <= 1'b0;
            r_dly_load <= 1'b0;
            r_done     <= 1'b0;
            r_mod_ack  <= 1'b0;
            if (i_abort) begin
                r_state    <= ST_IDLE;
                r_meas_req <= 1'b0;
                r_busy     <= 1'b0;
                r_single   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_scan_delay <= i_scan_first;
                            r_step_count <= '0;
                            r_sat_flag   <= 1'b0;
                            r_busy       <= 1'b1;
                            r_strb       <= 1'b1;
                            r_state      <= ST_APPLY;
                        end else if (i_mod_req) begin
                            r_delay_modifier <= i_mod_value;
                            r_mod_ack        <= 1'b1;
                            r_single         <= 1'b1;
                            r_strb           <= 1'b1;
                            r_state          <= ST_APPLY;
                        end
                    end
                    ST_APPLY: begin
                        r_dly_load <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (i_saturated) begin
                            r_sat_flag <= 1'b1;
                        end
                        if (r_single) begin
                            r_single <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else if (i_stop_on_sat && i_saturated) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (i_settle_cycles == '0) begin
                            r_meas_req <= 1'b1;
                            r_state    <= ST_MEAS;
                        end else begin
                            r_state <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (w_tmr_zero) begin
                            r_meas_req <= 1'b1;
                            r_state    <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        // End-of-scan is decided here so done lands one cycle after meas_done.
                        if (i_meas_done) begin
                            r_meas_req <= 1'b0;
                            if (r_step_count != '1) begin
                                r_step_count <= r_step_count + CNT_W'(1);
                            end
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_NEXT;
                                if (i_mod_req) begin
                                    r_delay_modifier <= i_mod_value;
                                    r_mod_ack        <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_NEXT: begin
                        r_scan_delay <= w_nxt[DLY_W-1:0];
                        r_strb       <= 1'b1;
                        r_state      <= ST_APPLY;
                        // A request already acknowledged on entry is still visible this cycle.
                        if (i_mod_req && !r_mod_ack) begin
                            r_delay_modifier <= i_mod_value;
                            r_mod_ack        <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_mod_ack        = r_mod_ack;
    assign o_meas_req       = r_meas_req;
    assign o_scan_delay     = r_scan_delay;
    assign o_delay_modifier = r_delay_modifier;
    assign o_strb           = r_strb;
    assign o_dly_load       = r_dly_load;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_sat_flag       = r_sat_flag;
    assign o_step_count     = r_step_count;

endmodule

// File: tb/tb_delay_scan_ctrl.sv
// Directed bench for delay_scan_ctrl with a scripted measurement responder.
module tb_delay_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] scan_first = '0;
    logic [5:0] scan_last = '0;
    logic [5:0] scan_step = '0;
    logic [7:0] settle_cycles = '0;
    logic       stop_on_sat = 1'b0;
    logic       saturated = 1'b0;
    logic       mod_req = 1'b0;
    logic [6:0] mod_value = '0;
    logic       mod_ack;
    logic       meas_req;
    logic       meas_done = 1'b0;
    logic [5:0] scan_delay;
    logic [6:0] delay_modifier;
    logic       strb;
    logic       dly_load;
    logic       busy;
    logic       done;
    logic       sat_flag;
    logic [6:0] step_count;

    int checks = 0;
    int failures = 0;

    // Responder controls (written by the test sequence only).
    int meas_lat = 0;
    bit sat_mode = 1'b0;
    int sat_at = 0;

    // Responder state.
    int lat_cnt = 0;
    int load_seen = 0;

    // Monitor state.
    int cyc = 0;
    int strb_cnt = 0;
    int done_cnt = 0;
    int ack_cnt = 0;
    int ack_in_meas = 0;
    int ack_strb_idx = 0;
    int last_md_cyc = 0;
    int last_strb_cyc = 0;
    int done_gap = 0;
    int strb_gap = 0;
    int strb_period = 0;
    logic [5:0] q_dly[$];
    logic [6:0] q_mod[$];

    delay_scan_ctrl #(.SETTLE_W(8)) dut (
        .i_clk40          (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_abort          (abort),
        .i_scan_first     (scan_first),
        .i_scan_last      (scan_last),
        .i_scan_step      (scan_step),
        .i_settle_cycles  (settle_cycles),
        .i_stop_on_sat    (stop_on_sat),
        .i_saturated      (saturated),
        .i_mod_req        (mod_req),
        .i_mod_value      (mod_value),
        .o_mod_ack        (mod_ack),
        .o_meas_req       (meas_req),
        .i_meas_done      (meas_done),
        .o_scan_delay     (scan_delay),
        .o_delay_modifier (delay_modifier),
        .o_strb           (strb),
        .o_dly_load       (dly_load),
        .o_busy           (busy),
        .o_done           (done),
        .o_sat_flag       (sat_flag),
        .o_step_count     (step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Measurement block and delay_calc saturation stand-in.
    always @(posedge clk) begin
        #1;
        saturated = sat_mode && dly_load && (load_seen == sat_at);
        if (dly_load) load_seen++;
        if (meas_done) begin
            meas_done = 1'b0;
        end else if (meas_req) begin
            if (lat_cnt >= meas_lat) begin
                meas_done = 1'b1;
                lat_cnt = 0;
            end else begin
                lat_cnt++;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (meas_done) last_md_cyc = cyc;
        if (strb) begin
            strb_gap = cyc - last_md_cyc;
            strb_period = cyc - last_strb_cyc;
            last_strb_cyc = cyc;
            strb_cnt++;
            q_dly.push_back(scan_delay);
            q_mod.push_back(delay_modifier);
        end
        if (done) begin
            done_cnt++;
            done_gap = cyc - last_md_cyc;
        end
        if (mod_ack) begin
            ack_cnt++;
            ack_strb_idx = strb_cnt;
            if (meas_req) ack_in_meas++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int maxc, output bit timed_out);
        int n = 0;
        while (busy === 1'b1 && n < maxc) begin
            step();
            n++;
        end
        timed_out = (busy !== 1'b0);
        step();
        step();
    endtask

    task automatic wait_meas(input int maxc, output bit timed_out);
        int n = 0;
        while (meas_req !== 1'b1 && n < maxc) begin
            step();
            n++;
        end
        timed_out = (meas_req !== 1'b1);
    endtask

    task automatic program_scan(input logic [5:0] f, input logic [5:0] l,
                                input logic [5:0] s, input logic [7:0] st, input int lat);
        scan_first = f;
        scan_last = l;
        scan_step = s;
        settle_cycles = st;
        meas_lat = lat;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (scan_delay !== 6'd0) begin failures++; $display("FAIL rst_scan_delay got=%0d exp=0", scan_delay); end
        checks++; if (delay_modifier !== 7'd0) begin failures++; $display("FAIL rst_modifier got=%0h exp=0", delay_modifier); end
        checks++; if ({mod_ack, meas_req, strb, dly_load, busy, done, sat_flag} !== 7'b0) begin
            failures++; $display("FAIL rst_flags got=%b exp=0000000", {mod_ack, meas_req, strb, dly_load, busy, done, sat_flag});
        end
        checks++; if (step_count !== 7'd0) begin failures++; $display("FAIL rst_step_count got=%0d exp=0", step_count); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_scan();
        int qb = q_dly.size();
        int db = done_cnt;
        bit to;
        program_scan(6'd10, 6'd20, 6'd5, 8'd3, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (strb !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_strb_c1 strb=%0b busy=%0b exp=1/1", strb, busy); end
        checks++; if (scan_delay !== 6'd10) begin failures++; $display("FAIL basic_first got=%0d exp=10", scan_delay); end
        step();
        checks++; if (dly_load !== 1'b1 || strb !== 1'b0) begin failures++; $display("FAIL basic_load_c2 dly_load=%0b strb=%0b exp=1/0", dly_load, strb); end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++; if (meas_req !== 1'b0) begin failures++; $display("FAIL basic_meas_early got=%0b exp=0", meas_req); end
        step();
        checks++; if (meas_req !== 1'b1) begin failures++; $display("FAIL basic_meas_c6 got=%0b exp=1", meas_req); end
        wait_idle(300, to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout busy=%0b exp=0", busy); end
        checks++; if (q_dly.size() - qb != 3) begin failures++; $display("FAIL basic_npoints got=%0d exp=3", q_dly.size() - qb); end
        else begin
            checks++; if (q_dly[qb] !== 6'd10 || q_dly[qb+1] !== 6'd15 || q_dly[qb+2] !== 6'd20) begin
                failures++; $display("FAIL basic_points got=%0d,%0d,%0d exp=10,15,20", q_dly[qb], q_dly[qb+1], q_dly[qb+2]);
            end
        end
        checks++; if (step_count !== 7'd3) begin failures++; $display("FAIL basic_step_count got=%0d exp=3", step_count); end
        checks++; if (done_cnt - db != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - db); end
        checks++; if (done_gap != 1) begin failures++; $display("FAIL basic_done_gap got=%0d exp=1", done_gap); end
        checks++; if (strb_gap != 2) begin failures++; $display("FAIL basic_strb_gap got=%0d exp=2", strb_gap); end
        checks++; if (scan_delay !== 6'd20 || sat_flag !== 1'b0) begin failures++; $display("FAIL basic_final dly=%0d sat=%0b exp=20/0", scan_delay, sat_flag); end
    endtask

    task automatic test_range_edges();
        int qb;
        int db;
        bit to;
        // Top of range: 60+8 would wrap in 6 bits.
        qb = q_dly.size(); db = done_cnt;
        program_scan(6'd60, 6'd63, 6'd8, 8'd0, 0);
        start = 1'b1; step(); start = 1'b0;
        wait_idle(100, to);
        checks++; if (to || q_dly.size() - qb != 1 || done_cnt - db != 1) begin
            failures++; $display("FAIL top_points to=%0b got=%0d done=%0d exp=1/1", to, q_dly.size() - qb, done_cnt - db);
        end
        checks++; if (scan_delay !== 6'd60 || step_count !== 7'd1) begin failures++; $display("FAIL top_hold dly=%0d cnt=%0d exp=60/1", scan_delay, step_count); end
        // Step 0 behaves as 1, minimum period.
        qb = q_dly.size(); db = done_cnt;
        program_scan(6'd0, 6'd3, 6'd0, 8'd0, 0);
        start = 1'b1; step(); start = 1'b0;
        wait_idle(100, to);
        checks++; if (to || q_dly.size() - qb != 4 || step_count !== 7'd4) begin
            failures++; $display("FAIL step0_points to=%0b got=%0d cnt=%0d exp=4/4", to, q_dly.size() - qb, step_count);
        end
        else begin
            checks++; if (q_dly[qb+3] !== 6'd3) begin failures++; $display("FAIL step0_last got=%0d exp=3", q_dly[qb+3]); end
        end
        checks++; if (strb_period != 4) begin failures++; $display("FAIL min_period got=%0d exp=4", strb_period); end
        // Inverted range: single point at scan_first.
        qb = q_dly.size(); db = done_cnt;
        program_scan(6'd30, 6'd5, 6'd2, 8'd1, 1);
        start = 1'b1; step(); start = 1'b0;
        wait_idle(100, to);
        checks++; if (to || q_dly.size() - qb != 1 || done_cnt - db != 1 || scan_delay !== 6'd30) begin
            failures++; $display("FAIL inverted to=%0b pts=%0d done=%0d dly=%0d exp=1/1/30", to, q_dly.size() - qb, done_cnt - db, scan_delay);
        end
    endtask

    task automatic test_stop_on_sat();
        int sb = strb_cnt;
        int db = done_cnt;
        bit to;
        program_scan(6'd4, 6'd40, 6'd3, 8'd1, 1);
        stop_on_sat = 1'b1;
        sat_at = load_seen + 1;
        sat_mode = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        wait_idle(200, to);
        sat_mode = 1'b0;
        stop_on_sat = 1'b0;
        checks++; if (to || strb_cnt - sb != 2) begin failures++; $display("FAIL sat_strbs to=%0b got=%0d exp=2", to, strb_cnt - sb); end
        checks++; if (step_count !== 7'd1 || sat_flag !== 1'b1) begin failures++; $display("FAIL sat_state cnt=%0d sat=%0b exp=1/1", step_count, sat_flag); end
        checks++; if (done_cnt - db != 0 || scan_delay !== 6'd7) begin failures++; $display("FAIL sat_nodone done=%0d dly=%0d exp=0/7", done_cnt - db, scan_delay); end
    endtask

    task automatic test_mod_in_meas();
        int qb = q_mod.size();
        int ab = ack_cnt;
        int im = ack_in_meas;
        int sb = strb_cnt;
        bit to;
        bit got = 1'b0;
        program_scan(6'd0, 6'd4, 6'd2, 8'd0, 3);
        start = 1'b1; step(); start = 1'b0;
        checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL mod_sat_clear got=%0b exp=0", sat_flag); end
        wait_meas(50, to);
        mod_value = 7'h7C;
        mod_req = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (mod_ack === 1'b1) got = 1'b1;
        end
        mod_req = 1'b0;
        wait_idle(200, to);
        checks++; if (!got || ack_cnt - ab != 1 || ack_in_meas != im) begin
            failures++; $display("FAIL mod_meas_ack got=%0b acks=%0d in_meas=%0d exp=1/1/0", got, ack_cnt - ab, ack_in_meas - im);
        end
        checks++; if (ack_strb_idx - sb != 1) begin failures++; $display("FAIL mod_meas_when strbs_before=%0d exp=1", ack_strb_idx - sb); end
        checks++; if (q_mod.size() - qb != 3) begin failures++; $display("FAIL mod_meas_pts got=%0d exp=3", q_mod.size() - qb); end
        else begin
            checks++; if (q_mod[qb+1] !== 7'h7C || q_mod[qb] === 7'h7C) begin
                failures++; $display("FAIL mod_meas_applied got=%0h,%0h exp=!7c,7c", q_mod[qb], q_mod[qb+1]);
            end
        end
        // Single-shot update from IDLE.
        mod_value = 7'h15;
        mod_req = 1'b1;
        step();
        mod_req = 1'b0;
        checks++; if (mod_ack !== 1'b1 || strb !== 1'b1 || delay_modifier !== 7'h15 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_mod_c1 ack=%0b strb=%0b mod=%0h busy=%0b exp=1/1/15/0", mod_ack, strb, delay_modifier, busy);
        end
        step();
        checks++; if (dly_load !== 1'b1 || mod_ack !== 1'b0) begin failures++; $display("FAIL idle_mod_c2 load=%0b ack=%0b exp=1/0", dly_load, mod_ack); end
        step();
        step();
        checks++; if ({strb, dly_load, meas_req, busy} !== 4'b0 || step_count !== 7'd3 || scan_delay !== 6'd4) begin
            failures++; $display("FAIL idle_mod_back got=%b cnt=%0d dly=%0d exp=0000/3/4", {strb, dly_load, meas_req, busy}, step_count, scan_delay);
        end
    endtask

    task automatic test_start_and_mod();
        int qb = q_mod.size();
        int sb = strb_cnt;
        bit to;
        bit got = 1'b0;
        program_scan(6'd8, 6'd9, 6'd1, 8'd2, 1);
        start = 1'b1;
        mod_req = 1'b1;
        mod_value = 7'h40;
        step();
        start = 1'b0;
        checks++; if (strb !== 1'b1 || busy !== 1'b1 || mod_ack !== 1'b0) begin
            failures++; $display("FAIL both_c1 strb=%0b busy=%0b ack=%0b exp=1/1/0", strb, busy, mod_ack);
        end
        for (int i = 0; i < 60 && !got; i++) begin
            if (mod_ack === 1'b1) got = 1'b1;
            else step();
        end
        mod_req = 1'b0;
        wait_idle(200, to);
        checks++; if (!got || ack_strb_idx - sb != 1) begin failures++; $display("FAIL both_ack got=%0b strbs_before=%0d exp=1/1", got, ack_strb_idx - sb); end
        checks++; if (to || q_mod.size() - qb != 2) begin failures++; $display("FAIL both_pts to=%0b got=%0d exp=2", to, q_mod.size() - qb); end
        else begin
            checks++; if (q_mod[qb] !== 7'h15 || q_mod[qb+1] !== 7'h40) begin
                failures++; $display("FAIL both_mods got=%0h,%0h exp=15,40", q_mod[qb], q_mod[qb+1]);
            end
        end
    endtask

    task automatic test_abort_reset();
        int db = done_cnt;
        int sb = strb_cnt;
        bit to;
        program_scan(6'd12, 6'd63, 6'd1, 8'd10, 5);
        start = 1'b1; step(); start = 1'b0;
        step();
        step();
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if ({strb, dly_load, meas_req, busy} !== 4'b0) begin failures++; $display("FAIL abort_outs got=%b exp=0000", {strb, dly_load, meas_req, busy}); end
        checks++; if (scan_delay !== 6'd12 || delay_modifier !== 7'h40) begin failures++; $display("FAIL abort_keep dly=%0d mod=%0h exp=12/40", scan_delay, delay_modifier); end
        for (int i = 0; i < 12; i++) step();
        checks++; if (meas_req !== 1'b0 || done_cnt != db || strb_cnt - sb != 1) begin
            failures++; $display("FAIL abort_quiet meas=%0b done=%0d strbs=%0d exp=0/0/1", meas_req, done_cnt - db, strb_cnt - sb);
        end
        start = 1'b1; step(); start = 1'b0;
        wait_meas(50, to);
        checks++; if (to) begin failures++; $display("FAIL reset_meas_timeout meas=%0b exp=1", meas_req); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({mod_ack, meas_req, strb, dly_load, busy, done, sat_flag} !== 7'b0 || scan_delay !== 6'd0
                      || delay_modifier !== 7'd0 || step_count !== 7'd0) begin
            failures++; $display("FAIL async_reset flags=%b dly=%0d mod=%0h cnt=%0d exp=0", {mod_ack, meas_req, strb, dly_load, busy, done, sat_flag},
                                 scan_delay, delay_modifier, step_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        checks++; if (done_cnt != db || busy !== 1'b0) begin failures++; $display("FAIL reset_nodone done=%0d busy=%0b exp=0/0", done_cnt - db, busy); end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_range_edges();
        test_stop_on_sat();
        test_mod_in_meas();
        test_start_and_mod();
        test_abort_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
